// File: rtl/flag_pkg.sv
// Shared opcode, flag-index and write-mask definitions for the EX-stage flag unit.
package flag_pkg;

  localparam logic [3:0] OPC_ADD    = 4'h0;
  localparam logic [3:0] OPC_SUB    = 4'h1;
  localparam logic [3:0] OPC_XOR    = 4'h2;
  localparam logic [3:0] OPC_AND    = 4'h3;
  localparam logic [3:0] OPC_SLL    = 4'h4;
  localparam logic [3:0] OPC_SRA    = 4'h5;
  localparam logic [3:0] OPC_ROR    = 4'h6;
  localparam logic [3:0] OPC_OR     = 4'h7;
  localparam logic [3:0] OPC_MOV    = 4'h8;
  localparam logic [3:0] OPC_LDI    = 4'h9;
  localparam logic [3:0] OPC_LD     = 4'hA;
  localparam logic [3:0] OPC_ST     = 4'hB;
  localparam logic [3:0] OPC_BR     = 4'hC;
  localparam logic [3:0] OPC_JMP    = 4'hD;
  localparam logic [3:0] OPC_NOP    = 4'hE;
  localparam logic [3:0] OPC_PADDSB = 4'hF;

  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [2:0] WM_NZV  = 3'b111;
  localparam logic [2:0] WM_Z    = 3'b010;
  localparam logic [2:0] WM_NONE = 3'b000;

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } flag_state_t;

endpackage

// File: rtl/flag_calc.sv
// Combinational flag generation: per-opcode {N,Z,V} values and the write mask.
module flag_calc
  import flag_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OPC_W  = 4
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] result,
  output logic [2:0]        flags,
  output logic [2:0]        wm
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              v_add;
  logic              v_sub;

  // Overflow uses the raw wrapped sum/difference, not the saturated result.
  assign sum   = op_a + op_b;
  assign diff  = op_a - op_b;
  assign v_add = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1]  != op_a[DATA_W-1]);
  assign v_sub = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]);

  always_comb begin
    flags         = '0;
    wm            = WM_NONE;
    flags[FLAG_N] = result[DATA_W-1];
    flags[FLAG_Z] = (result == '0);
    case (opcode)
      OPC_ADD: begin
        wm            = WM_NZV;
        flags[FLAG_V] = v_add;
      end
      OPC_SUB: begin
        wm            = WM_NZV;
        flags[FLAG_V] = v_sub;
      end
      OPC_XOR, OPC_SLL, OPC_SRA, OPC_ROR: wm = WM_Z;
      default: wm = WM_NONE;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// EX-stage condition-flag unit: stages one flag update, commits it a cycle later
// unless flushed, and forwards the youngest per-bit flag values to the branch unit.
module flag_unit
  import flag_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [OPC_W-1:0]  ex_opcode,
  input  logic [DATA_W-1:0] ex_op_a,
  input  logic [DATA_W-1:0] ex_op_b,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              stall,
  input  logic              flush,
  output logic [2:0]        flag_reg,
  output logic [2:0]        flag_fwd,
  output logic              flags_pending
);

  logic [2:0]  ex_flags;
  logic [2:0]  ex_wm;
  logic [2:0]  ex_act;
  logic [2:0]  older;

  flag_state_t state, state_nxt;
  logic [2:0]  pend_flags, pend_flags_nxt;
  logic [2:0]  pend_wm, pend_wm_nxt;
  logic [2:0]  arch_q, arch_nxt;

  flag_calc #(
    .DATA_W(DATA_W),
    .OPC_W (OPC_W)
  ) u_flag_calc (
    .opcode(ex_opcode),
    .op_a  (ex_op_a),
    .op_b  (ex_op_b),
    .result(ex_result),
    .flags (ex_flags),
    .wm    (ex_wm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pend_flags <= '0;
      pend_wm    <= '0;
      arch_q     <= '0;
    end else if (!stall) begin
      state      <= state_nxt;
      pend_flags <= pend_flags_nxt;
      pend_wm    <= pend_wm_nxt;
      arch_q     <= arch_nxt;
    end
  end

  // Pending entry keeps only its own masked bits; the merge happens at commit,
  // so a same-edge commit+capture naturally layers over the just-committed value.
  always_comb begin
    state_nxt      = ST_IDLE;
    pend_flags_nxt = '0;
    pend_wm_nxt    = '0;
    arch_nxt       = arch_q;
    if (!flush) begin
      if (state == ST_PEND)
        arch_nxt = (arch_q & ~pend_wm) | (pend_flags & pend_wm);
      if (ex_valid && (ex_wm != WM_NONE)) begin
        state_nxt      = ST_PEND;
        pend_flags_nxt = ex_flags;
        pend_wm_nxt    = ex_wm;
      end
    end
  end

  always_comb begin
    older  = (state == ST_PEND) ? ((arch_q & ~pend_wm) | (pend_flags & pend_wm)) : arch_q;
    ex_act = (ex_valid && !flush) ? ex_wm : WM_NONE;
  end

  assign flag_fwd      = (older & ~ex_act) | (ex_flags & ex_act);
  assign flag_reg      = arch_q;
  assign flags_pending = (state == ST_PEND);

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the flag pipeline.
module tb_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_op_a;
  logic [15:0] ex_op_b;
  logic [15:0] ex_result;
  logic        stall;
  logic        flush;
  logic [2:0]  flag_reg;
  logic [2:0]  flag_fwd;
  logic        flags_pending;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Reference state: architectural flags plus an optional in-flight update.
  logic [2:0] m_arch;
  logic       m_pend;
  logic [2:0] m_pf;
  logic [2:0] m_pm;

  always #5 clk = ~clk;

  flag_unit #(
    .DATA_W(16),
    .OPC_W (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_opcode    (ex_opcode),
    .ex_op_a      (ex_op_a),
    .ex_op_b      (ex_op_b),
    .ex_result    (ex_result),
    .stall        (stall),
    .flush        (flush),
    .flag_reg     (flag_reg),
    .flag_fwd     (flag_fwd),
    .flags_pending(flags_pending)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input int s);
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  // Flags from signed integer arithmetic: overflow means the true result leaves 16-bit range.
  function automatic void ref_flags(input logic [3:0] opc, input logic [15:0] a, b, r,
                                    output logic [2:0] f, output logic [2:0] m);
    int sa, sb, s;
    logic v;
    sa = $signed(a);
    sb = $signed(b);
    v  = 1'b0;
    if (opc == 4'h0) begin
      s = sa + sb;
      v = (s > 32767) || (s < -32768);
    end else if (opc == 4'h1) begin
      s = sa - sb;
      v = (s > 32767) || (s < -32768);
    end
    f = {r[15], (r == 16'h0000), v};
    if (opc == 4'h0 || opc == 4'h1)                            m = 3'b111;
    else if (opc == 4'h2 || opc == 4'h4 || opc == 4'h5 || opc == 4'h6) m = 3'b010;
    else                                                       m = 3'b000;
  endfunction

  function automatic logic [2:0] view(input logic [2:0] base, input logic [2:0] f, input logic [2:0] m);
    logic [2:0] o;
    for (int i = 0; i < 3; i++) o[i] = m[i] ? f[i] : base[i];
    return o;
  endfunction

  // One clock: apply inputs (just after a rising edge), check at the falling
  // edge, then advance the model at the next rising edge.
  task automatic step(input logic v, input logic [3:0] opc, input logic [15:0] a, b, r,
                      input logic st, input logic fl);
    logic [2:0] f, m, older, exp_fwd;
    ex_valid = v; ex_opcode = opc; ex_op_a = a; ex_op_b = b; ex_result = r;
    stall = st; flush = fl;
    ref_flags(opc, a, b, r, f, m);
    @(negedge clk);
    older   = m_pend ? view(m_arch, m_pf, m_pm) : m_arch;
    exp_fwd = (v && !fl) ? view(older, f, m) : older;
    chk("flag_fwd", {13'd0, flag_fwd}, {13'd0, exp_fwd});
    chk("flag_reg", {13'd0, flag_reg}, {13'd0, m_arch});
    chk("pending",  {15'd0, flags_pending}, {15'd0, m_pend});
    @(posedge clk);
    if (!st) begin
      if (fl) begin
        m_pend = 1'b0;
      end else begin
        if (m_pend) m_arch = view(m_arch, m_pf, m_pm);
        m_pend = v && (m != 3'b000);
        m_pf   = f;
        m_pm   = m;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'hE, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  // Reset asserted between clock edges and held across one rising edge.
  task automatic mid_reset();
    ex_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_reg",  {13'd0, flag_reg}, 16'h0000);
    chk("rst_pend", {15'd0, flags_pending}, 16'h0000);
    chk("rst_fwd",  {13'd0, flag_fwd}, 16'h0000);
    m_arch = '0; m_pend = 1'b0; m_pf = '0; m_pm = '0;
    @(negedge clk);
    chk("rst_hold_reg", {13'd0, flag_reg}, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      4: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  opc;
    logic [15:0] a, b, r;
    rst_n = 1'b0; ex_valid = 1'b0; ex_opcode = '0; ex_op_a = '0; ex_op_b = '0;
    ex_result = '0; stall = 1'b0; flush = 1'b0;
    m_arch = '0; m_pend = 1'b0; m_pf = '0; m_pm = '0;
    #3;
    chk("reset_reg",  {13'd0, flag_reg}, 16'h0000);
    chk("reset_fwd",  {13'd0, flag_fwd}, 16'h0000);
    chk("reset_pend", {15'd0, flags_pending}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Saturating ADD overflow: V visible immediately, architectural two edges later.
    step(1'b1, 4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b0);
    idle();
    chk("tp1_reg", {13'd0, flag_reg}, 16'h0001);
    mid_reset();

    // SUB to zero then XOR with negative result: only Z is rewritten.
    step(1'b1, 4'h1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 4'h2, 16'h1234, 16'h9234, 16'h8000, 1'b0, 1'b0);
    idle();
    idle();
    chk("tp2_reg", {13'd0, flag_reg}, 16'h0000);
    mid_reset();

    // Back-to-back: forwarded view mixes EX Z with pending N.
    step(1'b1, 4'h0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0);
    chk("tp3_pend", {15'd0, flags_pending}, 16'h0001);
    ex_valid = 1'b1; ex_opcode = 4'h4; ex_result = 16'h0000; stall = 1'b0; flush = 1'b0;
    #1;
    chk("tp3_fwd", {13'd0, flag_fwd}, 16'h0006);
    step(1'b1, 4'h4, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0);
    idle();
    idle();
    chk("tp3_reg", {13'd0, flag_reg}, 16'h0006);
    mid_reset();

    // Flush squashes a pending ADD.
    step(1'b1, 4'h0, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 4'hE, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("tp4_reg",  {13'd0, flag_reg}, 16'h0000);
    chk("tp4_pend", {15'd0, flags_pending}, 16'h0000);
    mid_reset();

    // Stall freezes everything, even with flush asserted; release then commits.
    step(1'b1, 4'h1, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
    chk("tp5_pend", {15'd0, flags_pending}, 16'h0001);
    idle();
    chk("tp5_reg", {13'd0, flag_reg}, 16'h0005);

    // Reset while an update is pending: nothing commits afterwards.
    step(1'b1, 4'h0, 16'h4000, 16'h4000, 16'h7FFF, 1'b0, 1'b0);
    mid_reset();
    idle();
    chk("tp6_reg", {13'd0, flag_reg}, 16'h0000);

    for (int n = 0; n < 600; n++) begin
      opc = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) opc = 4'($urandom_range(0, 1));
      a = pick_operand();
      b = pick_operand();
      if (opc == 4'h0)      r = sat16(int'($signed(a)) + int'($signed(b)));
      else if (opc == 4'h1) r = sat16(int'($signed(a)) - int'($signed(b)));
      else if ($urandom_range(0, 3) == 0) r = 16'h0000;
      else                  r = 16'($urandom);
      step($urandom_range(0, 5) != 0, opc, a, b, r,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Produces the 3-bit condition-flag register {N, Z, V} that the branch-condition evaluator consumes.
- Sits at the EX stage of the 16-bit pipeline and takes the ALU opcode, operands and (saturated) result.
- Computes which flags the instruction updates and stages the update one cycle, so a late flush can squash it before it becomes architectural.
- Provides a forwarded flag view so a branch resolving in ID sees the youngest in-flight flag values.

Parameters:
- DATA_W, 16, ALU operand/result width.
- OPC_W, 4, opcode field width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  EX stage holds a real instruction.
- ex_opcode  input  OPC_W  opcode of the EX instruction.
- ex_op_a  input  DATA_W  ALU operand A.
- ex_op_b  input  DATA_W  ALU operand B (already negated/selected is NOT assumed; raw rt value).
- ex_result  input  DATA_W  ALU result, saturated for ADD/SUB.
- stall  input  1  pipeline freeze; holds all state.
- flush  input  1  squash EX and the pending stage.
- flag_reg  output  3  architectural flags {N,Z,V}.
- flag_fwd  output  3  youngest flags for branch evaluation {N,Z,V}.
- flags_pending  output  1  high while the pending stage holds an uncommitted update.

Behaviour:
- Reset (async, rst_n low): flag_reg=3'b000, pending stage cleared, flags_pending=0, FSM=IDLE; flag_fwd therefore 3'b000.
- Update classes, decoded from ex_opcode:
  - ADD 0000, SUB 0001: write N, Z, V.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: write Z only.
  - All other opcodes: no write.
- Flag arithmetic:
  - N = ex_result[DATA_W-1]; Z = (ex_result == 0).
  - ADD: V = 1 iff a[15]==b[15] and (a+b)[15]!=a[15], using an internal unsaturated DATA_W-bit sum.
  - SUB (a-b): V = 1 iff a[15]!=b[15] and (a-b)[15]!=a[15].
  - N and Z always come from the saturated ex_result.
- Per-bit write mask wm[2:0]. Unmasked bits keep the value of the youngest older source: pending stage if valid, else flag_reg.
- FSM states:
  - IDLE: no pending update.
  - PEND: pending stage holds {flags, mask}.
- Each rising edge with stall=0:
  - Commit: if PEND and flush=0, flag_reg takes the pending flags on its masked bits.
  - Capture: if ex_valid, wm!=0 and flush=0, the pending stage captures the EX flags and mask; next state PEND. Otherwise next state IDLE.
  - Commit and capture in the same edge is legal: the new pending entry is merged against the just-committed value.
- flush=1 (stall=0): pending entry and EX update are discarded, FSM→IDLE, flag_reg unchanged.
- stall=1: all registers hold, including during flush. Flush is honoured only with stall=0.
- flag_fwd (combinational), bit by bit, priority: EX masked bit (if ex_valid & !flush) > pending masked bit (if PEND) > flag_reg.
- flags_pending = (state==PEND).
- Latency:
  - flag_fwd reflects an EX instruction in the same cycle.
  - flag_reg reflects it 2 edges after it enters EX (assuming no stall).
- Reset asserted mid-operation: pending entry lost, flag_reg cleared immediately.

Decomposition:
- Shared package flag_pkg:
  - opcode localparams (OPC_ADD…OPC_PADDSB).
  - flag bit indices FLAG_N=2, FLAG_Z=1, FLAG_V=0.
  - write-mask constants WM_NZV=3'b111, WM_Z=3'b010, WM_NONE=3'b000.
- One sub-module: flag_calc (combinational). Takes opcode, operands and result; returns flags[2:0] and wm[2:0]. This keeps the sequential commit/forward logic separate and lets flag_calc be unit-tested exhaustively.

Test Plan:
- ADD a=16'h7FFF, b=16'h0001, result saturated 16'h7FFF → flag_fwd=3'b001 same cycle; flag_reg=3'b001 after 2 edges.
- SUB a=16'h0005, b=16'h0005, result 0 → flag_fwd=3'b010; then XOR result 16'h8000 → only Z changes, flag_reg=3'b000, N stays 0.
- Back-to-back: ADD (result 16'hFFFE, flags 100) then SLL (result 0) → flag_fwd=110 while SLL in EX and ADD pending; final flag_reg=110.
- ADD with result 0 in pending, flush=1 → flag_reg stays at the previous value 000, flags_pending drops next edge.
- stall=1 for 3 cycles with PEND and flush=1 → all state frozen; after stall release with flush=0 the pending update commits.
- rst_n pulled low asynchronously mid-cycle while PEND → flag_reg=000, flags_pending=0 immediately, no commit on the next edge.
